tictactoe_board_ctrl: RTL and testbench

- Sequential owner of the 3x3 tic-tac-toe board: accepts player/computer move strobes, validates them, writes cell registers and alternates turns.
- Drives pos1..pos9 into the combinational winner_detector and takes winner/who back to end the game or declare a draw.
- Sits between the move sources (buttons, computer move generator) and the winner_detector/display logic.

---
 rtl/tictactoe_board_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_tictactoe_board_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tictactoe_board_ctrl.sv
// Tic-tac-toe board controller.
//
// Owns the 3x3 board. Validates and applies player/computer move strobes and
// alternates turns. After every accepted move it spends one CHECK cycle reading
// the external winner detector, then either hands the turn over or ends the game.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous active-low reset
//   new_game     synchronous clear of board and FSM, overrides any strobe
//   play, pc     one-cycle move strobes (player / computer)
//   move_pos     target cell 1..9, sampled with the accepted strobe
//   winner, who  from the combinational winner detector (who: 01 player, 10 computer)
//   pos1..pos9   cell states: 00 empty, 01 player, 10 computer
//   turn         0 player to move, 1 computer to move (held through CHECK/DONE)
//   illegal_move one-cycle pulse after a rejected move by the side to move
//   game_over    high in DONE
//   result       00 in play or draw, 01 player won, 10 computer won
//   draw         high in DONE when the board filled up with no winner
//   move_count   accepted moves in this game, 0..9
module tictactoe_board_ctrl #(
  parameter bit FIRST_MOVER = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       new_game,
  input  logic       play,
  input  logic       pc,
  input  logic [3:0] move_pos,
  input  logic       winner,
  input  logic [1:0] who,
  output logic [1:0] pos1,
  output logic [1:0] pos2,
  output logic [1:0] pos3,
  output logic [1:0] pos4,
  output logic [1:0] pos5,
  output logic [1:0] pos6,
  output logic [1:0] pos7,
  output logic [1:0] pos8,
  output logic [1:0] pos9,
  output logic       turn,
  output logic       illegal_move,
  output logic       game_over,
  output logic [1:0] result,
  output logic       draw,
  output logic [3:0] move_count
);

  typedef enum logic [1:0] {
    StPTurn,
    StCTurn,
    StCheck,
    StDone
  } state_e;

  localparam state_e     StInit     = FIRST_MOVER ? StCTurn : StPTurn;
  localparam logic [1:0] CellEmpty  = 2'b00;
  localparam logic [1:0] CellPlayer = 2'b01;
  localparam logic [1:0] CellPc     = 2'b10;
  localparam logic [1:0] CellNone   = 2'b11;

  state_e          state_q, state_d;
  logic [8:0][1:0] cells_q, cells_d;
  logic [3:0]      count_q, count_d;
  logic            last_q, last_d;      // 0 player moved last, 1 computer
  logic            illegal_q, illegal_d;
  logic [1:0]      result_q, result_d;
  logic            draw_q, draw_d;
  logic            turn_q, turn_d;

  logic [1:0]      target;
  logic            target_ok;

  // Out-of-range positions read as CellNone so they fail the empty test.
  always_comb begin
    target = CellNone;
    for (int i = 0; i < 9; i++) begin
      if (move_pos == 4'(i + 1)) begin
        target = cells_q[i];
      end
    end
  end

  assign target_ok = (target == CellEmpty);

  always_comb begin
    state_d   = state_q;
    cells_d   = cells_q;
    count_d   = count_q;
    last_d    = last_q;
    illegal_d = 1'b0;
    result_d  = result_q;
    draw_d    = draw_q;

    unique case (state_q)
      StPTurn: begin
        if (play) begin
          if (target_ok) begin
            for (int i = 0; i < 9; i++) begin
              if (move_pos == 4'(i + 1)) begin
                cells_d[i] = CellPlayer;
              end
            end
            count_d = count_q + 4'd1;
            last_d  = 1'b0;
            state_d = StCheck;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      StCTurn: begin
        if (pc) begin
          if (target_ok) begin
            for (int i = 0; i < 9; i++) begin
              if (move_pos == 4'(i + 1)) begin
                cells_d[i] = CellPc;
              end
            end
            count_d = count_q + 4'd1;
            last_d  = 1'b1;
            state_d = StCheck;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      StCheck: begin
        if (winner) begin
          state_d  = StDone;
          result_d = who;
          draw_d   = 1'b0;
        end else if (count_q == 4'd9) begin
          state_d  = StDone;
          result_d = 2'b00;
          draw_d   = 1'b1;
        end else begin
          state_d = last_q ? StPTurn : StCTurn;
        end
      end
      StDone: begin
        // Frozen until new_game or reset.
      end
      default: begin
        state_d = StInit;
      end
    endcase

    if (new_game) begin
      state_d   = StInit;
      cells_d   = '0;
      count_d   = 4'd0;
      last_d    = 1'b0;
      illegal_d = 1'b0;
      result_d  = 2'b00;
      draw_d    = 1'b0;
    end

    // turn follows the turn states and holds through CHECK/DONE.
    if (state_d == StCTurn) begin
      turn_d = 1'b1;
    end else if (state_d == StPTurn) begin
      turn_d = 1'b0;
    end else begin
      turn_d = turn_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StInit;
      cells_q   <= '0;
      count_q   <= 4'd0;
      last_q    <= 1'b0;
      illegal_q <= 1'b0;
      result_q  <= 2'b00;
      draw_q    <= 1'b0;
      turn_q    <= FIRST_MOVER;
    end else begin
      state_q   <= state_d;
      cells_q   <= cells_d;
      count_q   <= count_d;
      last_q    <= last_d;
      illegal_q <= illegal_d;
      result_q  <= result_d;
      draw_q    <= draw_d;
      turn_q    <= turn_d;
    end
  end

  assign pos1         = cells_q[0];
  assign pos2         = cells_q[1];
  assign pos3         = cells_q[2];
  assign pos4         = cells_q[3];
  assign pos5         = cells_q[4];
  assign pos6         = cells_q[5];
  assign pos7         = cells_q[6];
  assign pos8         = cells_q[7];
  assign pos9         = cells_q[8];
  assign turn         = turn_q;
  assign illegal_move = illegal_q;
  assign game_over    = (state_q == StDone);
  assign result       = result_q;
  assign draw         = draw_q;
  assign move_count   = count_q;

endmodule

// File: tb/tb_tictactoe_board_ctrl.sv
// Directed bench for tictactoe_board_ctrl. A behavioural winner detector closes
// the loop on the main instance; a second instance built with FIRST_MOVER=1
// covers the computer-first reset state.
module tb_tictactoe_board_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       new_game;
  logic       play, pc;
  logic [3:0] move_pos;
  logic       winner;
  logic [1:0] who;
  logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
  logic       turn, illegal_move, game_over, draw;
  logic [1:0] result;
  logic [3:0] move_count;

  logic       pc2;
  logic [3:0] move_pos2;
  logic [1:0] p2 [9];
  logic       turn2, illegal2, game_over2, draw2;
  logic [1:0] result2;
  logic [3:0] count2;

  logic [17:0] board;
  logic [1:0]  mb [1:9];   // bench model of the board
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;

  tictactoe_board_ctrl #(.FIRST_MOVER(1'b0)) dut (
    .clock(clock), .reset(reset), .new_game(new_game), .play(play), .pc(pc),
    .move_pos(move_pos), .winner(winner), .who(who),
    .pos1(pos1), .pos2(pos2), .pos3(pos3), .pos4(pos4), .pos5(pos5),
    .pos6(pos6), .pos7(pos7), .pos8(pos8), .pos9(pos9),
    .turn(turn), .illegal_move(illegal_move), .game_over(game_over),
    .result(result), .draw(draw), .move_count(move_count)
  );

  tictactoe_board_ctrl #(.FIRST_MOVER(1'b1)) dut2 (
    .clock(clock), .reset(reset), .new_game(new_game), .play(1'b0), .pc(pc2),
    .move_pos(move_pos2), .winner(1'b0), .who(2'b00),
    .pos1(p2[0]), .pos2(p2[1]), .pos3(p2[2]), .pos4(p2[3]), .pos5(p2[4]),
    .pos6(p2[5]), .pos7(p2[6]), .pos8(p2[7]), .pos9(p2[8]),
    .turn(turn2), .illegal_move(illegal2), .game_over(game_over2),
    .result(result2), .draw(draw2), .move_count(count2)
  );

  assign board = {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};

  function automatic logic win3(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
    return (a != 2'b00) && (a == b) && (b == c);
  endfunction

  // Reference winner detector.
  always_comb begin
    winner = 1'b0;
    who    = 2'b00;
    if (win3(pos1, pos2, pos3)) begin winner = 1'b1; who = pos1; end
    if (win3(pos4, pos5, pos6)) begin winner = 1'b1; who = pos4; end
    if (win3(pos7, pos8, pos9)) begin winner = 1'b1; who = pos7; end
    if (win3(pos1, pos4, pos7)) begin winner = 1'b1; who = pos1; end
    if (win3(pos2, pos5, pos8)) begin winner = 1'b1; who = pos2; end
    if (win3(pos3, pos6, pos9)) begin winner = 1'b1; who = pos3; end
    if (win3(pos1, pos5, pos9)) begin winner = 1'b1; who = pos1; end
    if (win3(pos3, pos5, pos7)) begin winner = 1'b1; who = pos3; end
  end

  function automatic logic [17:0] model_board();
    logic [17:0] b;
    for (int i = 1; i <= 9; i++) begin
      b[2*(i-1) +: 2] = mb[i];
    end
    return b;
  endfunction

  task automatic clear_model();
    for (int i = 1; i <= 9; i++) begin
      mb[i] = 2'b00;
    end
  endtask

  task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One-cycle strobe; returns 1 ns after the edge that sampled it.
  task automatic drive(input logic p, input logic c, input logic [3:0] m);
    play     = p;
    pc       = c;
    move_pos = m;
    tick();
    play     = 1'b0;
    pc       = 1'b0;
    move_pos = 4'd0;
  endtask

  int seq [9];

  initial begin
    reset = 1'b0; new_game = 1'b0; play = 1'b0; pc = 1'b0; move_pos = 4'd0;
    pc2 = 1'b0; move_pos2 = 4'd0;
    clear_model();
    seq = '{1, 2, 3, 5, 4, 6, 8, 7, 9};

    // Reset state
    #12;
    chk("rst_board", board, 18'd0);
    chk("rst_count", 18'(move_count), 18'd0);
    chk("rst_turn", 18'(turn), 18'd0);
    chk("rst_over", 18'(game_over), 18'd0);
    chk("rst_result", 18'(result), 18'd0);
    chk("rst_draw", 18'(draw), 18'd0);
    chk("rst_illegal", 18'(illegal_move), 18'd0);
    chk("rst_turn_fm1", 18'(turn2), 18'd1);
    reset = 1'b1;
    tick();

    // P5 then C1
    drive(1'b1, 1'b0, 4'd5); mb[5] = 2'b01;
    chk("p5_board", board, model_board());
    chk("p5_count", 18'(move_count), 18'd1);
    chk("p5_illegal", 18'(illegal_move), 18'd0);
    tick();
    chk("p5_turn", 18'(turn), 18'd1);
    drive(1'b0, 1'b1, 4'd1); mb[1] = 2'b10;
    chk("c1_board", board, model_board());
    chk("c1_count", 18'(move_count), 18'd2);
    chk("c1_illegal", 18'(illegal_move), 18'd0);
    tick();
    chk("c1_turn", 18'(turn), 18'd0);

    // Rejected moves
    drive(1'b1, 1'b0, 4'd5);
    chk("occ5_illegal", 18'(illegal_move), 18'd1);
    chk("occ5_board", board, model_board());
    chk("occ5_count", 18'(move_count), 18'd2);
    chk("occ5_turn", 18'(turn), 18'd0);
    tick();
    chk("occ5_pulse_end", 18'(illegal_move), 18'd0);
    drive(1'b1, 1'b0, 4'd1);
    chk("occ1_illegal", 18'(illegal_move), 18'd1);
    chk("occ1_board", board, model_board());
    drive(1'b1, 1'b0, 4'd0);
    chk("pos0_illegal", 18'(illegal_move), 18'd1);
    drive(1'b1, 1'b0, 4'd12);
    chk("pos12_illegal", 18'(illegal_move), 18'd1);
    chk("pos12_board", board, model_board());
    tick();
    chk("pos12_pulse_end", 18'(illegal_move), 18'd0);

    // Wrong-turn strobe, then simultaneous strobes
    drive(1'b0, 1'b1, 4'd3);
    chk("wrong_turn_illegal", 18'(illegal_move), 18'd0);
    chk("wrong_turn_board", board, model_board());
    drive(1'b1, 1'b1, 4'd7); mb[7] = 2'b01;
    chk("both_board", board, model_board());
    chk("both_count", 18'(move_count), 18'd3);
    tick();
    chk("both_turn", 18'(turn), 18'd1);

    // new_game beats a concurrent strobe
    new_game = 1'b1;
    drive(1'b0, 1'b1, 4'd9);
    new_game = 1'b0;
    clear_model();
    chk("ng_board", board, 18'd0);
    chk("ng_count", 18'(move_count), 18'd0);
    chk("ng_turn", 18'(turn), 18'd0);

    // Player wins top row: P1 C4 P2 C5 P3
    drive(1'b1, 1'b0, 4'd1); mb[1] = 2'b01; tick();
    drive(1'b0, 1'b1, 4'd4); mb[4] = 2'b10; tick();
    drive(1'b1, 1'b0, 4'd2); mb[2] = 2'b01; tick();
    drive(1'b0, 1'b1, 4'd5); mb[5] = 2'b10; tick();
    drive(1'b1, 1'b0, 4'd3); mb[3] = 2'b01;
    chk("win_pre_over", 18'(game_over), 18'd0);
    chk("win_count", 18'(move_count), 18'd5);
    tick();
    chk("win_over", 18'(game_over), 18'd1);
    chk("win_result", 18'(result), 18'd1);
    chk("win_draw", 18'(draw), 18'd0);
    drive(1'b1, 1'b0, 4'd9);
    chk("done_play_board", board, model_board());
    chk("done_play_illegal", 18'(illegal_move), 18'd0);
    drive(1'b0, 1'b1, 4'd8);
    chk("done_pc_board", board, model_board());
    chk("done_count", 18'(move_count), 18'd5);
    chk("done_result_held", 18'(result), 18'd1);

    // new_game from DONE
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    clear_model();
    chk("ngd_board", board, 18'd0);
    chk("ngd_count", 18'(move_count), 18'd0);
    chk("ngd_result", 18'(result), 18'd0);
    chk("ngd_over", 18'(game_over), 18'd0);
    chk("ngd_turn", 18'(turn), 18'd0);

    // Draw: P1 C2 P3 C5 P4 C6 P8 C7 P9
    for (int i = 0; i < 9; i++) begin
      drive((i % 2) == 0, (i % 2) == 1, 4'(seq[i]));
      mb[seq[i]] = ((i % 2) == 0) ? 2'b01 : 2'b10;
      if (i < 8) begin
        tick();
        chk("draw_turn", 18'(turn), ((i % 2) == 0) ? 18'd1 : 18'd0);
      end
    end
    chk("draw_board", board, model_board());
    chk("draw_count", 18'(move_count), 18'd9);
    chk("draw_pre_over", 18'(game_over), 18'd0);
    tick();
    chk("draw_over", 18'(game_over), 18'd1);
    chk("draw_flag", 18'(draw), 18'd1);
    chk("draw_result", 18'(result), 18'd0);

    // Reset asserted while in CHECK
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    clear_model();
    drive(1'b1, 1'b0, 4'd5);
    reset = 1'b0;
    #1;
    chk("rstck_board", board, 18'd0);
    chk("rstck_count", 18'(move_count), 18'd0);
    chk("rstck_result", 18'(result), 18'd0);
    chk("rstck_turn", 18'(turn), 18'd0);
    chk("rstck_turn_fm1", 18'(turn2), 18'd1);
    reset = 1'b1;
    drive(1'b1, 1'b0, 4'd2); mb[2] = 2'b01;
    chk("rstck_pturn_move", board, model_board());

    // Computer-first instance accepts pc from reset
    pc2 = 1'b1;
    move_pos2 = 4'd9;
    tick();
    pc2 = 1'b0;
    move_pos2 = 4'd0;
    chk("fm1_pos9", 18'(p2[8]), 18'd2);
    chk("fm1_count", 18'(count2), 18'd1);
    chk("fm1_illegal", 18'(illegal2), 18'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
